// File: rtl/ifetch_pkg.sv
// Shared types, opcode constants and immediate decoders for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Instruction buffer: power-of-two FIFO with synchronous flush and occupancy count.
module ifetch_buf #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential fetch, in-order response buffering, redirect drain.
// Static branch prediction is compiled in only when IFETCH_STATIC_PRED_EN is defined.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_pred_taken
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = XLEN + 32 + 1;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d, buf_count;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_fire, rsp_keep, pred_fire, redir_any;
  logic            buf_empty, buf_full_unused;
  logic [EW-1:0]   head;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_fire  = imem_req_valid && imem_req_ready;
  // a response with nothing outstanding is stale (e.g. from before reset) and is ignored
  assign rsp_fire  = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep  = rsp_fire && (discard_q == '0) && !redirect_valid;
  assign occupancy = {1'b0, inflight_q} + {1'b0, buf_count};

`ifdef IFETCH_STATIC_PRED_EN
  logic [6:0]      rsp_op;
  logic [31:0]     pred_imm;
  logic [XLEN-1:0] pred_tgt;
  assign rsp_op    = imem_rsp_data[6:0];
  assign pred_fire = rsp_keep && ((rsp_op == OP_BRANCH && imem_rsp_data[31]) || rsp_op == OP_JAL);
  assign pred_imm  = (rsp_op == OP_JAL) ? imm_j(imem_rsp_data) : imm_b(imem_rsp_data);
  assign pred_tgt  = rsp_pc_q + XLEN'($signed(pred_imm));
`else
  assign pred_fire = 1'b0;
`endif
  assign redir_any = redirect_valid || pred_fire;

  // requests are held back in the redirect cycle so the new target is what gets issued next
  assign imem_req_valid = (state_q == FETCH) && !redir_any && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = redirect_valid ? redir_pc : fetch_pc_q;

  always_comb begin
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    state_d    = state_q;
    if (rsp_fire && discard_q != '0) discard_d = discard_q - CW'(1);
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(4);
    case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (!fetch_en) state_d = IDLE;
      DRAIN:   if (discard_d == '0) state_d = fetch_en ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
    if (redir_any) begin
      discard_d = inflight_q - CW'(rsp_fire);
      state_d   = (discard_d != '0) ? DRAIN : (fetch_en ? FETCH : IDLE);
    end
`ifdef IFETCH_STATIC_PRED_EN
    if (pred_fire) begin
      fetch_pc_d = pred_tgt;
      rsp_pc_d   = pred_tgt;
    end
`endif
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  ifetch_buf #(.W(EW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({rsp_pc_q, imem_rsp_data, pred_fire}),
    .pop       (out_valid && out_ready),
    .head_data (head),
    .full      (buf_full_unused),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign out_valid      = !buf_empty;
  assign out_pc         = buf_empty ? '0 : head[EW-1 -: XLEN];
  assign out_inst       = buf_empty ? NOP : head[32:1];
  assign out_pred_taken = !buf_empty && head[0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit with a one-cycle-latency instruction memory.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        out_pred_taken;

  int n_checks = 0;
  int n_pass   = 0;

  logic        mem_hold, beq_en;
  logic [31:0] mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] out_log[$];

  ifetch_unit #(.XLEN(32), .BUF_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_pred_taken (out_pred_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // BEQ x0,x0,-16 at 0x20 when beq_en, otherwise an R-type word that encodes the address
  function automatic logic [31:0] word(input logic [31:0] a);
    return (beq_en && a == 32'h20) ? 32'hFE00_08E3 : {a[24:0], 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    logic        acc, rsp, pop;
    logic [31:0] aaddr, ppc;
    #2;
    acc   = imem_req_valid && imem_req_ready;
    aaddr = imem_req_addr;
    rsp   = imem_rsp_valid;
    pop   = out_valid && out_ready;
    ppc   = out_pc;
    @(posedge clk);
    #1;
    if (rsp && mem_q.size() > 0) void'(mem_q.pop_front());
    if (acc) begin
      mem_q.push_back(aaddr);
      req_log.push_back(aaddr);
    end
    if (pop) out_log.push_back(ppc);
    imem_rsp_valid = !mem_hold && (mem_q.size() > 0);
    imem_rsp_data  = (mem_q.size() > 0) ? word(mem_q[0]) : 32'h0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
  endtask

  task automatic do_reset(input logic fen);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_req_valid", imem_req_valid, 0);
    mem_q.delete();
    imem_rsp_valid = 1'b0;
    ticks(2);
    rst_n    = 1'b1;
    fetch_en = fen;
    req_log.delete();
    out_log.delete();
  endtask

  initial begin
    rst_n = 0; fetch_en = 0; imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 1; mem_hold = 0; beq_en = 0;
    ticks(2);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_inst", out_inst, 32'h13);
    chk("reset_pred", out_pred_taken, 0);

    // sequential fetch with a one-cycle memory
    rst_n = 1; fetch_en = 1;
    tick();
    chk("A_req_valid", imem_req_valid, 1);
    chk("A_req_addr0", imem_req_addr, 32'h0);
    tick();
    chk("A_no_out_before_rsp", out_valid, 0);
    tick();
    chk("A_out_valid_after_rsp", out_valid, 1);
    chk("A_out_pc0", out_pc, 32'h0);
    chk("A_out_inst0", out_inst, word(32'h0));
    ticks(6);
    chk("A_req_count", req_log.size() >= 3, 1);
    chk("A_out_count", out_log.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("A_req_seq", req_log[i], 32'(4 * i));
      chk("A_out_seq", out_log[i], 32'(4 * i));
    end

    // back-pressure: outstanding + buffered never exceeds the buffer depth
    out_ready = 0;
    do_reset(1);
    ticks(12);
    chk("B_req_bounded", req_log.size(), 2);
    chk("B_out_valid", out_valid, 1);
    chk("B_head_pc", out_pc, 32'h0);
    out_ready = 1;
    ticks(10);
    chk("B_out_count", out_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("B_no_loss", out_log[i], 32'(4 * i));

    // redirect with two requests in flight
    mem_hold = 1;
    do_reset(1);
    ticks(3);
    chk("C_two_inflight", req_log.size(), 2);
    redirect_valid = 1; redirect_pc = 32'h103;
    #1;
    chk("C_addr_replaced", imem_req_addr, 32'h100);
    tick();
    redirect_valid = 0; mem_hold = 0;
    chk("C_drain_no_req", imem_req_valid, 0);
    tick();
    chk("C_drain_out_valid", out_valid, 0);
    chk("C_drain_no_req2", imem_req_valid, 0);
    out_log.delete();
    wait_out("C");
    chk("C_next_pc", out_pc, 32'h100);
    chk("C_next_inst", out_inst, word(32'h100));
    chk("C_req_after_redirect", req_log[2], 32'h100);

    // redirect coincident with an arriving response and a pop
    do_reset(1);
    ticks(3);
    chk("D_pre_out_pc", out_pc, 32'h0);
    redirect_valid = 1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 0;
    chk("D_pop_count", out_log.size(), 1);
    chk("D_popped_pc", out_log[0], 32'h0);
    chk("D_flushed", out_valid, 0);
    wait_out("D");
    chk("D_next_pc", out_pc, 32'h200);
    tick();
    chk("D_deliver_count", out_log.size(), 2);
    chk("D_deliver_pc", out_log[1], 32'h200);

    // reset with two requests in flight; stale responses afterwards are ignored
    mem_hold = 1;
    do_reset(1);
    ticks(3);
    rst_n = 0;
    #1;
    chk("E_out_valid_async", out_valid, 0);
    chk("E_req_valid_async", imem_req_valid, 0);
    fetch_en = 0; mem_hold = 0;
    ticks(2);
    rst_n = 1;
    ticks(3);
    chk("E_stale_ignored", out_valid, 0);
    chk("E_idle_no_req", imem_req_valid, 0);
    req_log.delete();
    fetch_en = 1;
    tick();
    chk("E_first_req_valid", imem_req_valid, 1);
    chk("E_first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("E_first_req_log", req_log.size() >= 1 && req_log[0] == 32'h0, 1);

    // fetch address wraps at the top of the address space
    do_reset(0);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; fetch_en = 1;
    tick();
    redirect_valid = 0;
    ticks(6);
    chk("F_req_top", req_log[0], 32'hFFFF_FFFC);
    chk("F_req_wrap", req_log[1], 32'h0);
    chk("F_out_top", out_log[0], 32'hFFFF_FFFC);
    chk("F_out_wrap", out_log[1], 32'h0);

    // backward BEQ at 0x20 with offset -16
    beq_en = 1;
    do_reset(0);
    redirect_valid = 1; redirect_pc = 32'h20; fetch_en = 1;
    tick();
    redirect_valid = 0;
    wait_out("G");
    chk("G_pc", out_pc, 32'h20);
    chk("G_inst", out_inst, 32'hFE00_08E3);
`ifdef IFETCH_STATIC_PRED_EN
    chk("G_pred", out_pred_taken, 1);
`else
    chk("G_pred", out_pred_taken, 0);
`endif
    tick();
    wait_out("G2");
`ifdef IFETCH_STATIC_PRED_EN
    chk("G_next_pc", out_pc, 32'h10);
`else
    chk("G_next_pc", out_pc, 32'h24);
`endif
    chk("G_next_pred", out_pred_taken, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries and max in-flight requests; power of two, >=2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 clk  input  1  the block's one clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 fetch_en  input  1  permits new memory requests when high.
REQ-007 imem_req_valid  output  1  request valid; imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  in-order response valid; imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  and redirect_pc  input  XLEN  branch/jump correction from execute.
REQ-011 out_valid  output  1, out_ready  input  1, out_pc  output  XLEN, out_inst  output  32  decode-side handshake.
REQ-012 out_pred_taken  output  1  static prediction flag for out_inst.

Function
REQ-013 States IDLE, FETCH, DRAIN; IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0; any state->DRAIN on redirect with in-flight>0, else ->FETCH/IDLE per fetch_en; DRAIN->FETCH/IDLE when discard count reaches 0.
REQ-014 imem_req_valid=1 only in FETCH when in-flight+buffered < BUF_DEPTH; request issues on valid&ready; fetch PC then +4 (wraps modulo 2^XLEN).
REQ-015 imem_req_addr/valid SHALL hold stable until accepted unless a redirect arrives, which replaces the address in the same cycle it is seen.
REQ-016 Each non-discarded response is written to the buffer tagged with its request PC; out_valid rises the cycle after the response (one-cycle latency).
REQ-017 Buffer is FIFO; out handshake pops on out_valid&out_ready; simultaneous push and pop when full-minus-zero allowed, occupancy unchanged.
REQ-018 Redirect: buffer flushed, fetch PC := redirect_pc, discard count := in-flight count (including a response arriving that same cycle, which is dropped); a pop in the same cycle is still counted delivered.
REQ-019 In DRAIN, responses decrement discard count and are dropped; no requests issued.
REQ-020 Response with in-flight=0 is a protocol error: ignored, no state change.
REQ-021 redirect_pc[1:0] ignored (forced 00).

Reset
REQ-022 On rst_n low: state IDLE, fetch PC=RESET_PC, buffer empty, in-flight=0, discard=0, out_valid=0, imem_req_valid=0, out_pc=0, out_inst=32'h0000_0013, out_pred_taken=0.
REQ-023 Reset mid-transaction abandons in-flight requests; first request after release goes to RESET_PC; stale responses after reset are ignored per REQ-020.

Configuration
REQ-024 Macro IFETCH_STATIC_PRED_EN: when defined, a buffered B-type with negative offset or any JAL sets out_pred_taken=1 and triggers internal redirect to pc+imm, discarding younger in-flight/buffered fetches exactly as REQ-018.
REQ-025 Without IFETCH_STATIC_PRED_EN: out_pred_taken tied 0, sequential fetch only, predecode logic absent.

Structure
REQ-026 Shared package holds state enum, opcode constants (OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, NOP 32'h13) and immediate-extract helpers.
REQ-027 Sub-module ifetch_buf: parametrised FIFO (XLEN+32+1 bits wide, BUF_DEPTH deep) with flush, full, empty, count.

Verification
REQ-028 Reset release, fetch_en=1, memory 1-cycle ready -> requests 0x0,0x4,0x8; out_pc sequence identical, out_valid one cycle after each response.
REQ-029 out_ready=0 for 10 cycles -> at most BUF_DEPTH requests outstanding+buffered; no loss when out_ready returns.
REQ-030 Redirect to 0x100 with two in-flight -> both responses dropped, next out_pc=0x100.
REQ-031 Redirect coincident with response and pop -> popped entry delivered once, response dropped.
REQ-032 rst_n low with 2 in-flight -> out_valid=0 immediately, first request 0x0 after release.
REQ-033 With IFETCH_STATIC_PRED_EN, BEQ at 0x20 offset -16 -> out_pred_taken=1, next out_pc=0x10.
